// File: rtl/sys_onchip_pkg.sv
// Shared constants and helpers for the dual-port on-chip RAM.
// The read latency and byte-lane count are derived here so every file agrees.
package sys_onchip_pkg;

   localparam int BYTE_W = 8;

   function automatic int calc_lat(input int out_reg);
      return (out_reg != 0) ? 2 : 1;
   endfunction

   function automatic int byte_lanes(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/sys_onchip_rd_pipe.sv
// Read-return pipeline for one port: valid shift of depth LAT plus the data
// stages behind the RAM output register, frozen by en and cleared by reset.
module sys_onchip_rd_pipe #(
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LAT-1:0] vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (en) begin
         vld[0] <= in_valid;
         for (int k = 1; k < LAT; k++) begin
            vld[k] <= vld[k-1];
         end
      end
   end

   assign out_valid = vld[LAT-1];

   // in_data is already the registered RAM word aligned with vld[0]; later
   // stages only load when a valid word reaches them, so the output holds.
   generate
      if (LAT > 1) begin : g_dly
         logic [DATA_W-1:0] dly [LAT-1];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < LAT - 1; k++) begin
                  dly[k] <= '0;
               end
            end else if (en) begin
               if (vld[0]) begin
                  dly[0] <= in_data;
               end
               for (int k = 1; k < LAT - 1; k++) begin
                  if (vld[k]) begin
                     dly[k] <= dly[k-1];
                  end
               end
            end
         end

         assign out_data = dly[LAT-2];
      end else begin : g_direct
         assign out_data = in_data;
      end
   endgenerate

endmodule

// File: rtl/sys_onchip_ram_dp.sv
// True dual-port on-chip RAM with byte enables and two Avalon-MM slave ports.
// Read data returns LAT enabled cycles after an accepted read.
module sys_onchip_ram_dp
   import sys_onchip_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int OUT_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic                  reset_req,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid
);

   localparam int              LAT     = calc_lat(OUT_REG);
   localparam int              NB      = byte_lanes(DATA_W);
   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   // Handshake: an access is taken on any enabled cycle with chipselect high
   // (no waitrequest); readdatavalid qualifies exactly one word per read.
   logic en;
   logic s1_in, s2_in, s1_wr, s2_wr, s1_rd, s2_rd;
   logic [IDX_W-1:0] s1_idx, s2_idx;
   logic [DATA_W-1:0] s1_q, s2_q;
   logic [DATA_W-1:0] mem [DEPTH];

   assign en     = clken & ~reset_req;
   assign s1_in  = {1'b0, s1_address} < DEPTH_L;
   assign s2_in  = {1'b0, s2_address} < DEPTH_L;
   assign s1_idx = s1_address[IDX_W-1:0];
   assign s2_idx = s2_address[IDX_W-1:0];
   assign s1_wr  = en & ~reset & s1_chipselect & s1_write;
   assign s2_wr  = en & ~reset & s2_chipselect & s2_write;
   assign s1_rd  = en & ~reset & s1_chipselect & s1_read & ~s1_write;
   assign s2_rd  = en & ~reset & s2_chipselect & s2_read & ~s2_write;

   // s2 lanes are written first so s1 overrides them on a same-address collision.
   always_ff @(posedge clk) begin
      if (s2_wr && s2_in) begin
         for (int i = 0; i < NB; i++) begin
            if (s2_byteenable[i]) mem[s2_idx][i*BYTE_W +: BYTE_W] <= s2_writedata[i*BYTE_W +: BYTE_W];
         end
      end
      if (s1_wr && s1_in) begin
         for (int i = 0; i < NB; i++) begin
            if (s1_byteenable[i]) mem[s1_idx][i*BYTE_W +: BYTE_W] <= s1_writedata[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Output registers of the RAM sample pre-write contents (old-data behaviour).
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         if (s1_rd) s1_q <= s1_in ? mem[s1_idx] : '0;
         if (s2_rd) s2_q <= s2_in ? mem[s2_idx] : '0;
      end
   end

   sys_onchip_rd_pipe #(.DATA_W(DATA_W), .LAT(LAT)) u_s1_pipe (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (s1_rd),
      .in_data   (s1_q),
      .out_valid (s1_readdatavalid),
      .out_data  (s1_readdata)
   );

   sys_onchip_rd_pipe #(.DATA_W(DATA_W), .LAT(LAT)) u_s2_pipe (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (s2_rd),
      .in_data   (s2_q),
      .out_valid (s2_readdatavalid),
      .out_data  (s2_readdata)
   );

endmodule

// File: tb/tb_sys_onchip_ram_dp.sv
// Directed bench for sys_onchip_ram_dp (DEPTH=1000, OUT_REG=1, so LAT=2).
// Expected read words and due cycles are queued per port and matched on each pulse.
module tb_sys_onchip_ram_dp;

   localparam int DW    = 32;
   localparam int DEPTH = 1000;
   localparam int AW    = 10;
   localparam int LAT   = 2;

   logic          clk = 1'b0;
   logic          reset, clken, reset_req;
   logic [AW-1:0] s1_address, s2_address;
   logic [3:0]    s1_byteenable, s2_byteenable;
   logic          s1_chipselect, s1_read, s1_write;
   logic          s2_chipselect, s2_read, s2_write;
   logic [DW-1:0] s1_writedata, s2_writedata;
   logic [DW-1:0] s1_readdata, s2_readdata;
   logic          s1_readdatavalid, s2_readdatavalid;

   int            n_cmp = 0;
   int            n_err = 0;
   int            ecnt  = 0;
   logic [DW-1:0] exp_q [2][$];
   int            due_q [2][$];
   logic [DW-1:0] nxt_exp [2];
   logic          prev_v [2];
   logic [DW-1:0] prev_d [2];

   sys_onchip_ram_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .clken            (clken),
      .reset_req        (reset_req),
      .s1_address       (s1_address),
      .s1_byteenable    (s1_byteenable),
      .s1_chipselect    (s1_chipselect),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s2_address       (s2_address),
      .s2_byteenable    (s2_byteenable),
      .s2_chipselect    (s2_chipselect),
      .s2_read          (s2_read),
      .s2_write         (s2_write),
      .s2_writedata     (s2_writedata),
      .s2_readdata      (s2_readdata),
      .s2_readdatavalid (s2_readdatavalid)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic clr();
      s1_address = '0; s1_byteenable = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_writedata = '0;
      s2_address = '0; s2_byteenable = '0; s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_writedata = '0;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      if (p == 0) begin
         s1_address = a; s1_writedata = d; s1_byteenable = be; s1_chipselect = 1; s1_write = 1;
      end else begin
         s2_address = a; s2_writedata = d; s2_byteenable = be; s2_chipselect = 1; s2_write = 1;
      end
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a, input logic [31:0] e);
      nxt_exp[p] = e;
      if (p == 0) begin
         s1_address = a; s1_chipselect = 1; s1_read = 1;
      end else begin
         s2_address = a; s2_chipselect = 1; s2_read = 1;
      end
   endtask

   // scoreboard for one port, evaluated #1 after each edge
   task automatic mon(input int p, input logic v, input logic [31:0] d, input logic en_e, input logic rst_e);
      string pfx;
      pfx = $sformatf("s%0d", p + 1);
      if (rst_e) begin
         exp_q[p].delete();
         due_q[p].delete();
         check({pfx, "_reset_valid"}, 32'(v), 32'd0);
         check({pfx, "_reset_data"}, d, 32'd0);
      end else if (!en_e) begin
         check({pfx, "_stall_valid"}, 32'(v), 32'(prev_v[p]));
         check({pfx, "_stall_data"}, d, prev_d[p]);
      end else if (v) begin
         if (exp_q[p].size() == 0) begin
            check({pfx, "_spurious_valid"}, 32'(v), 32'd0);
         end else begin
            check({pfx, "_rdata"}, d, exp_q[p].pop_front());
            check({pfx, "_latency"}, ecnt, due_q[p].pop_front());
         end
      end else begin
         check({pfx, "_hold_data"}, d, prev_d[p]);
         if (due_q[p].size() > 0 && due_q[p][0] <= ecnt) begin
            check({pfx, "_missing_valid"}, 32'(v), 32'd1);
            void'(exp_q[p].pop_front());
            void'(due_q[p].pop_front());
         end
      end
      prev_v[p] = v;
      prev_d[p] = d;
   endtask

   task automatic step();
      logic en_e, rst_e, acc0, acc1;
      en_e  = clken & ~reset_req;
      rst_e = reset;
      acc0  = en_e & ~reset & s1_chipselect & s1_read & ~s1_write;
      acc1  = en_e & ~reset & s2_chipselect & s2_read & ~s2_write;
      @(posedge clk);
      #1;
      if (en_e) ecnt++;
      if (acc0) begin exp_q[0].push_back(nxt_exp[0]); due_q[0].push_back(ecnt + LAT - 1); end
      if (acc1) begin exp_q[1].push_back(nxt_exp[1]); due_q[1].push_back(ecnt + LAT - 1); end
      mon(0, s1_readdatavalid, s1_readdata, en_e, rst_e);
      mon(1, s2_readdatavalid, s2_readdata, en_e, rst_e);
      clr();
   endtask

   initial begin
      clr();
      reset = 1; clken = 1; reset_req = 0;
      for (int p = 0; p < 2; p++) begin prev_v[p] = 0; prev_d[p] = '0; nxt_exp[p] = '0; end
      step(); step();
      reset = 0;

      // write then read back with two-cycle latency
      wr(0, 5, 32'hDEADBEEF, 4'hF); step();
      rd(0, 5, 32'hDEADBEEF); step(); step(); step();

      // partial byte write from port 2
      wr(0, 7, 32'h11223344, 4'hF); step();
      wr(1, 7, 32'hAABBCCDD, 4'b0101); step();
      rd(1, 7, 32'h11BB33DD); step(); step(); step();

      // same-address collision, then mixed-port read-during-write both ways
      wr(0, 9, 32'h12345678, 4'hF); step();
      wr(0, 9, 32'h00000000, 4'b0011); wr(1, 9, 32'hFFFFFFFF, 4'hF); step();
      rd(1, 9, 32'hFFFF0000); wr(0, 9, 32'h01020304, 4'hF); step();
      rd(0, 9, 32'h01020304); wr(1, 9, 32'h0BADF00D, 4'hF); step();
      rd(1, 9, 32'h0BADF00D); step(); step(); step();

      // read together with write on one port is a write only
      wr(0, 11, 32'h13572468, 4'hF); s1_read = 1; step();
      rd(0, 11, 32'h13572468); step(); step(); step();

      // back-to-back reads on both ports
      rd(0, 5, 32'hDEADBEEF); rd(1, 11, 32'h13572468); step();
      rd(0, 7, 32'h11BB33DD); rd(1, 9, 32'h0BADF00D); step();
      rd(0, 9, 32'h0BADF00D); rd(1, 5, 32'hDEADBEEF); step();
      step(); step();

      // clken stall while a read is in flight
      rd(0, 7, 32'h11BB33DD); step();
      clken = 0; step(); step(); step();
      clken = 1; step(); step(); step();

      // reset_req stall; writes presented meanwhile are dropped
      rd(1, 5, 32'hDEADBEEF); step();
      reset_req = 1; wr(0, 5, 32'h00000000, 4'hF); step();
      wr(0, 5, 32'h00000000, 4'hF); step();
      reset_req = 0; step(); step();
      rd(0, 5, 32'hDEADBEEF); step(); step(); step();

      // out-of-range accesses
      wr(0, 999, 32'h99999999, 4'hF); step();
      wr(0, 1000, 32'h5A5A5A5A, 4'hF); step();
      rd(0, 1000, 32'h00000000); rd(1, 1023, 32'h00000000); step();
      rd(0, 999, 32'h99999999); step(); step(); step();

      // reset one cycle after a read drops it and keeps memory
      wr(0, 3, 32'hCAFEF00D, 4'hF); step();
      rd(0, 3, 32'hCAFEF00D); step();
      reset = 1; wr(1, 3, 32'h00000000, 4'hF); rd(0, 3, 32'h00000000); step();
      reset = 0; step();
      rd(0, 3, 32'hCAFEF00D); rd(1, 3, 32'hCAFEF00D); step(); step(); step();

      step(); step();
      check("s1_pending_reads", exp_q[0].size(), 32'd0);
      check("s2_pending_reads", exp_q[1].size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
